// File: rtl/alu_input_ctrl.sv
// Board-level sequencer for a combinational ALU: loads A, B and the opcode from the switches on
// successive button presses, then captures the ALU result for the LEDs. Optional ALU_CTRL_DEBOUNCE_EN adds a debounce filter on each button.
module alu_input_ctrl #(
  parameter int NB_DATA   = 8,
  parameter int NB_OP     = 6,
  parameter int DB_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NB_DATA-1:0] i_sw,
  input  logic [2:0]         i_btn,
  input  logic [NB_DATA-1:0] i_alu_out,
  output logic [NB_DATA-1:0] o_dato_a,
  output logic [NB_DATA-1:0] o_dato_b,
  output logic [NB_OP-1:0]   o_opcode,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_done,
  output logic               o_seq_err,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t     state, next_state;
  logic [2:0] sync1, sync2;
  logic [2:0] level, level_d;
  logic [2:0] pulse;
  logic       load_a, load_b, load_op, capture, accept, reject;

  // Buttons are asynchronous to clk, so two flops guard against metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_btn;
      sync2 <= sync1;
    end
  end

`ifdef ALU_CTRL_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  for (genvar i = 0; i < 3; i++) begin : g_db
    logic          filt;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        filt <= 1'b0;
        cnt  <= '0;
      end else if (sync2[i] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        filt <= sync2[i];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign level[i] = filt;
  end
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_d <= '0;
    else        level_d <= level;
  end

  // Rising edge only: a held button gives one pulse, release gives none.
  assign pulse = level & ~level_d;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    unique case (state)
      S_LOAD_A, S_DONE: begin
        if (pulse[0]) begin
          load_a     = 1'b1;
          accept     = 1'b1;
          next_state = S_LOAD_B;
        end else if (|pulse) begin
          reject = 1'b1;
        end
      end
      S_LOAD_B: begin
        if (pulse[1]) begin
          load_b     = 1'b1;
          accept     = 1'b1;
          next_state = S_LOAD_OP;
        end else if (|pulse) begin
          reject = 1'b1;
        end
      end
      S_LOAD_OP: begin
        if (pulse[2]) begin
          load_op    = 1'b1;
          accept     = 1'b1;
          next_state = S_EXEC;
        end else if (|pulse) begin
          reject = 1'b1;
        end
      end
      S_EXEC: begin
        capture    = 1'b1;
        next_state = S_DONE;
      end
      default: next_state = S_LOAD_A;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD_A;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_dato_a  <= '0;
      o_dato_b  <= '0;
      o_opcode  <= '0;
      o_result  <= '0;
      o_done    <= 1'b0;
      o_seq_err <= 1'b0;
    end else begin
      if (load_a)  o_dato_a <= i_sw;
      if (load_b)  o_dato_b <= i_sw;
      if (load_op) o_opcode <= i_sw[NB_OP-1:0];
      if (capture) o_result <= i_alu_out;

      if (capture)     o_done <= 1'b1;
      else if (load_a) o_done <= 1'b0;

      if (accept)      o_seq_err <= 1'b0;
      else if (reject) o_seq_err <= 1'b1;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Self-checking bench for alu_input_ctrl: a small ALU model closes the loop, then a vector
// table plus hand-written sequences cover ordering, latency, held buttons and async reset.
module tb_alu_input_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_sw;
  logic [2:0] i_btn;
  logic [7:0] i_alu_out;
  logic [7:0] o_dato_a, o_dato_b, o_result;
  logic [5:0] o_opcode;
  logic       o_done, o_seq_err;
  logic [2:0] o_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_input_ctrl #(.NB_DATA(8), .NB_OP(6), .DB_CYCLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_sw      (i_sw),
    .i_btn     (i_btn),
    .i_alu_out (i_alu_out),
    .o_dato_a  (o_dato_a),
    .o_dato_b  (o_dato_b),
    .o_opcode  (o_opcode),
    .o_result  (o_result),
    .o_done    (o_done),
    .o_seq_err (o_seq_err),
    .o_state   (o_state)
  );

  // Reference ALU sitting between the sequencer outputs and i_alu_out.
  always_comb begin
    i_alu_out = 8'h00;
    case (o_opcode)
      6'h20: i_alu_out = o_dato_a + o_dato_b;
      6'h22: i_alu_out = o_dato_a - o_dato_b;
      6'h24: i_alu_out = o_dato_a & o_dato_b;
      6'h25: i_alu_out = o_dato_a | o_dato_b;
      6'h26: i_alu_out = o_dato_a ^ o_dato_b;
      6'h27: i_alu_out = ~(o_dato_a | o_dato_b);
      default: i_alu_out = 8'h00;
    endcase
  end

  typedef struct {
    string      name;
    int         btn;
    logic [7:0] sw;
    logic [2:0] state;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic press(input int b, input logic [7:0] sw, input int hold);
    @(negedge clk);
    i_sw     = sw;
    i_btn[b] = 1'b1;
    repeat (hold) @(negedge clk);
    i_btn = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    i_btn = '0;
    i_sw  = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic [7:0] a,
                           input logic [7:0] b, input logic [5:0] op, input logic [7:0] res,
                           input logic dn, input logic er);
    check({tag, ".state"}, 32'(o_state), 32'(st));
    check({tag, ".a"}, 32'(o_dato_a), 32'(a));
    check({tag, ".b"}, 32'(o_dato_b), 32'(b));
    check({tag, ".op"}, 32'(o_opcode), 32'(op));
    check({tag, ".res"}, 32'(o_result), 32'(res));
    check({tag, ".done"}, 32'(o_done), 32'(dn));
    check({tag, ".err"}, 32'(o_seq_err), 32'(er));
  endtask

  initial begin
    //          name       btn sw     st    a      b      op     res    done err
    vecs[0] = '{"t1_a",    0, 8'h02, 3'd1, 8'h02, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{"t1_b",    1, 8'h08, 3'd2, 8'h02, 8'h08, 6'h00, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{"t1_op",   2, 8'h20, 3'd4, 8'h02, 8'h08, 6'h20, 8'h0A, 1'b1, 1'b0};
    vecs[3] = '{"t2_a",    0, 8'h08, 3'd1, 8'h08, 8'h08, 6'h20, 8'h0A, 1'b0, 1'b0};
    vecs[4] = '{"t2_b",    1, 8'h02, 3'd2, 8'h08, 8'h02, 6'h20, 8'h0A, 1'b0, 1'b0};
    vecs[5] = '{"t2_op",   2, 8'h22, 3'd4, 8'h08, 8'h02, 6'h22, 8'h06, 1'b1, 1'b0};
    vecs[6] = '{"done_b1", 1, 8'hFF, 3'd4, 8'h08, 8'h02, 6'h22, 8'h06, 1'b1, 1'b1};
    vecs[7] = '{"done_a",  0, 8'h03, 3'd1, 8'h03, 8'h02, 6'h22, 8'h06, 1'b0, 1'b0};

    do_reset();
    check_all("reset", 3'd0, 8'h00, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      press(vecs[i].btn, vecs[i].sw, 4);
      check_all(vecs[i].name, vecs[i].state, vecs[i].a, vecs[i].b, vecs[i].op,
                vecs[i].res, vecs[i].done, vecs[i].err);
    end

    // Out-of-order press in S_LOAD_A, then recovery.
    do_reset();
    press(1, 8'hFF, 4);
    check_all("t3_err", 3'd0, 8'h00, 8'h00, 6'h00, 8'h00, 1'b0, 1'b1);
    press(0, 8'h11, 4);
    check_all("t3_ok", 3'd1, 8'h11, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0);

    // Simultaneous btn0+btn1 in S_LOAD_B: btn1 accepted, no error.
    @(negedge clk);
    i_sw  = 8'h05;
    i_btn = 3'b011;
    repeat (4) @(negedge clk);
    i_btn = '0;
    repeat (4) @(negedge clk);
    check_all("simul", 3'd2, 8'h11, 8'h05, 6'h00, 8'h00, 1'b0, 1'b0);

    // Load latency: btn2 first sampled at edge k, opcode at k+2, result/done at k+3.
    @(negedge clk);
    i_sw  = 8'h20;
    i_btn = 3'b100;
    repeat (2) @(posedge clk);
    #1 check("lat_k1.op", 32'(o_opcode), 32'h00);
    @(posedge clk);
    #1;
    check("lat_k2.op", 32'(o_opcode), 32'h20);
    check("lat_k2.state", 32'(o_state), 32'd3);
    check("lat_k2.done", 32'(o_done), 32'd0);
    @(posedge clk);
    #1;
    check("lat_k3.res", 32'(o_result), 32'h16);
    check("lat_k3.done", 32'(o_done), 32'd1);
    check("lat_k3.state", 32'(o_state), 32'd4);
    i_btn = '0;
    repeat (4) @(negedge clk);

    // Held button: one load only, later switch change is ignored.
    do_reset();
    @(negedge clk);
    i_sw  = 8'h05;
    i_btn = 3'b001;
    repeat (100) @(negedge clk);
    i_sw = 8'h07;
    repeat (10) @(negedge clk);
    i_btn = '0;
    repeat (4) @(negedge clk);
    check_all("hold", 3'd1, 8'h05, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0);

    // Async reset mid-cycle while in S_LOAD_OP.
    press(1, 8'h09, 4);
    check("pre_rst.state", 32'(o_state), 32'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 3'd0, 8'h00, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst.state", 32'(o_state), 32'd0);
    press(0, 8'h44, 4);
    check_all("post_rst_a", 3'd1, 8'h44, 8'h00, 6'h00, 8'h00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
